// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants.
// The receiver uses it today; the transmitter will use it later.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 32'd8;
    localparam int unsigned UART_OVERSAMPLE = 32'd16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_receiver_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 (line idle) so reset release never looks like a start bit.
module rx_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage metastability filter, preset to the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit validation at mid bit, LSB-first data,
// single stop bit. Framing errors park the FSM in RECOVER until the line is high.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 32'd1) ? $clog2(DATA_BITS) : 32'd1;

    // Count value seen just before the tick that reaches mid start bit.
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 32'd2 - 32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 32'd1);
    localparam logic [BW-1:0] IDX_ONE  = BW'(32'd1);

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_nxt_s;
    logic [BW-1:0]        idx_q, idx_d, idx_nxt_s;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    rx_synchronizer u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (rx),
        .sync_o  (rx_s)
    );

    // Next-state, counter, shift register and output-pulse decode.
    always_comb begin
        state_d   = state_q;
        cnt_nxt_s = cnt_q;
        idx_nxt_s = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (cnt_q == CNT_HALF) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;      // glitch, not a real start bit
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        cnt_nxt_s = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_q;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_nxt_s = '0;
                        shift_d   = shift_q >> 1;
                        shift_d[DATA_BITS-1] = rx_s;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            idx_nxt_s = idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_q;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        data_d = shift_q;
                        if (rx_s) begin
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_RECOVER;
                        end
                    end else begin
                        cnt_nxt_s = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_q;
                end
            end
            ST_RECOVER: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counters restart on every state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            cnt_d = cnt_nxt_s;
            idx_d = idx_nxt_s;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the number of data bits per frame, LSB first.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, giving the number of tick pulses per bit period; it must be even and at least 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: single-cycle strobe at OVERSAMPLE x baud, driven by the team's baud rate generator.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, DATA_BITS bits: the last received frame payload.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data holds a correctly framed byte.
REQ-009 The block SHALL have port frame_error, output, 1 bit: one-clk pulse when the stop bit is sampled low.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all logic below SHALL use only the synchronized value rx_s (2-clk latency).
REQ-012 The FSM SHALL have exactly five states: IDLE, START, DATA, STOP, RECOVER.
REQ-013 A tick counter SHALL advance only on clk cycles with tick=1, SHALL clear on every state entry, and SHALL have width $clog2(OVERSAMPLE).
REQ-014 In IDLE, rx_s=0 SHALL move the FSM to START on the next clk, regardless of tick.
REQ-015 In START, on the tick that brings the count to OVERSAMPLE/2 (mid start bit), rx_s=0 SHALL move the FSM to DATA; rx_s=1 SHALL return it to IDLE as a false start, with no output pulse.
REQ-016 In DATA, every OVERSAMPLE ticks SHALL sample rx_s into a shift register, LSB first, and increment a bit index; after DATA_BITS samples the FSM SHALL move to STOP.
REQ-017 In STOP, on the OVERSAMPLE-th tick, rx_s=1 SHALL load rx_data, pulse rx_valid on the next clk, and return to IDLE.
REQ-018 In STOP, on the OVERSAMPLE-th tick, rx_s=0 SHALL load rx_data, pulse frame_error on the next clk without rx_valid, and go to RECOVER.
REQ-019 RECOVER SHALL go to IDLE on the first clk with rx_s=1 (break/line-low protection).
REQ-020 rx_valid and frame_error SHALL never be high in the same cycle; each SHALL be exactly 1 clk wide.
REQ-021 rx_data SHALL hold its value until the next stop-bit sample; it SHALL be unaffected by false starts and aborted frames.
REQ-022 With tick held low, the FSM and counters SHALL hold, except for the transitions IDLE->START and RECOVER->IDLE.
REQ-023 Back-to-back frames SHALL be accepted with zero idle bits; the next start edge is detected in IDLE the clk after the return from STOP.

Reset
REQ-024 Asserting reset at any time, including mid-frame, SHALL immediately force: state=IDLE, counters=0, shift register=0, rx_data=0, rx_valid=0, frame_error=0, busy=0.
REQ-025 The synchronizer flops SHALL reset to 1 so that no false start is seen after reset release.

Structure
REQ-026 The FSM state encoding and the default OVERSAMPLE and DATA_BITS constants SHALL live in the shared package uart_pkg, also used by the future transmitter.
REQ-027 The 2-flop synchronizer SHALL be the sub-module rx_synchronizer; all else SHALL be flat in uart_receiver.

Verification
REQ-028 Test: tick every 4 clk, send 0xA5 with 1 stop bit -> rx_data=0xA5, one rx_valid pulse, frame_error=0, busy low afterwards.
REQ-029 Test: rx low for 3 ticks then high -> no pulses, FSM back in IDLE, rx_data unchanged.
REQ-030 Test: send 0x3C with the stop bit low and rx held low for 40 ticks -> rx_data=0x3C, one frame_error pulse, no rx_valid, busy high until rx returns high.
REQ-031 Test: 0x00 followed immediately by 0xFF with no idle gap -> two rx_valid pulses, with values 0x00 then 0xFF.
REQ-032 Test: reset asserted during data bit 4 of 0x55, then 0x81 sent -> outputs zero during reset, then only 0x81 is reported.
REQ-033 Test: tick held low for 100 clk mid-DATA, then resumed -> byte still received correctly.
